// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider
//
// Multi-cycle restoring divider for DIV/IDIV. One quotient bit is produced per
// clock. Operands are captured when start is accepted in IDLE. Results and the
// error flag are presented together with a one-cycle complete pulse.
//
// Ports
//   clk        core clock
//   reset      synchronous, active-high reset
//   start      request pulse, only honoured while idle
//   is_8_bit   1: 16/8 divide (AX / r8), 0: 32/16 divide (DX:AX / r16)
//   is_signed  1: IDIV semantics, 0: DIV semantics
//   dividend   32-bit dividend (8-bit mode uses [15:0])
//   divisor    16-bit divisor (8-bit mode uses [7:0])
//   quotient   quotient, zero-extended in 8-bit mode, 0 on error
//   remainder  remainder, zero-extended in 8-bit mode, 0 on error
//   busy       high while a division is in flight
//   complete   one-cycle pulse when results/error are valid
//   error      divide error, held until the next accepted start
// ---------------------------------------------------------------------------
module divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_8_bit,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        complete,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_DIVIDE,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t      state_reg;

    // Latched operands and mode
    logic [31:0] a_reg;
    logic [15:0] b_reg;
    logic        is8_reg;
    logic        sgn_reg;

    // Datapath: q_reg shifts the low dividend half out and quotient bits in;
    // pr_reg is the partial remainder (the extra top bit lives only in the
    // shifted compare value).
    logic [15:0] q_reg;
    logic [15:0] pr_reg;
    logic [15:0] dvs_reg;
    logic [3:0]  cnt_reg;
    logic        q_neg_reg;
    logic        r_neg_reg;
    logic        ovf_reg;
    logic        err_pend_reg;

    // INIT-stage combinational values
    logic        a_sign;
    logic        b_sign;
    logic [31:0] a_abs;
    logic [15:0] b_abs;
    logic [15:0] abs_hi;
    logic [15:0] abs_lo;
    logic        hi_ovf;
    logic        div_zero;

    // DIVIDE-stage combinational values
    logic        in_bit;
    logic [16:0] shifted;
    logic        ge;
    logic [15:0] pr_next;

    // FIXUP-stage combinational values
    logic [15:0] res_mask;
    logic [15:0] q_res;
    logic [15:0] r_res;
    logic        q_big;
    logic        sgn_ovf;

    always_comb begin
        a_sign = is8_reg ? a_reg[15] : a_reg[31];
        b_sign = is8_reg ? b_reg[7]  : b_reg[15];

        // Magnitudes of the operands; unsigned mode passes them through.
        if (is8_reg) begin
            a_abs = {16'h0000, (sgn_reg && a_sign) ? -a_reg[15:0] : a_reg[15:0]};
            b_abs = {8'h00, (sgn_reg && b_sign) ? -b_reg[7:0] : b_reg[7:0]};
            abs_hi = {8'h00, a_abs[15:8]};
            abs_lo = {8'h00, a_abs[7:0]};
        end else begin
            a_abs  = (sgn_reg && a_sign) ? -a_reg : a_reg;
            b_abs  = (sgn_reg && b_sign) ? -b_reg : b_reg;
            abs_hi = a_abs[31:16];
            abs_lo = a_abs[15:0];
        end

        // Upper half not below the divisor means the quotient needs more
        // than N bits.
        hi_ovf   = (abs_hi >= b_abs);
        div_zero = (b_abs == 16'h0000);

        // One restoring step: shift the next dividend bit into the partial
        // remainder and subtract the divisor if it fits.
        in_bit  = is8_reg ? q_reg[7] : q_reg[15];
        shifted = {pr_reg, in_bit};
        ge      = (shifted >= {1'b0, dvs_reg});
        // Low 16 bits of the difference are exact because the true result
        // is smaller than the divisor.
        pr_next = ge ? (shifted[15:0] - dvs_reg) : shifted[15:0];

        res_mask = is8_reg ? 16'h00FF : 16'hFFFF;
        q_res    = (q_neg_reg ? -q_reg : q_reg) & res_mask;
        r_res    = (r_neg_reg ? -pr_reg : pr_reg) & res_mask;

        // A magnitude with the top bit set exceeds 2^(N-1)-1; this also
        // rejects the most negative value, matching the 8086.
        q_big   = is8_reg ? q_reg[7] : q_reg[15];
        sgn_ovf = sgn_reg && (ovf_reg || q_big);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            is8_reg      <= 1'b0;
            sgn_reg      <= 1'b0;
            q_reg        <= '0;
            pr_reg       <= '0;
            dvs_reg      <= '0;
            cnt_reg      <= '0;
            q_neg_reg    <= 1'b0;
            r_neg_reg    <= 1'b0;
            ovf_reg      <= 1'b0;
            err_pend_reg <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            busy         <= 1'b0;
            complete     <= 1'b0;
            error        <= 1'b0;
        end else begin
            complete <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        a_reg     <= dividend;
                        b_reg     <= divisor;
                        is8_reg   <= is_8_bit;
                        sgn_reg   <= is_signed;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        state_reg <= S_INIT;
                    end
                end

                S_INIT: begin
                    q_reg        <= abs_lo;
                    pr_reg       <= abs_hi;
                    dvs_reg      <= b_abs;
                    cnt_reg      <= is8_reg ? 4'd7 : 4'd15;
                    q_neg_reg    <= sgn_reg && (a_sign ^ b_sign);
                    r_neg_reg    <= sgn_reg && a_sign;
                    ovf_reg      <= hi_ovf;
                    // Signed mode defers a large upper half to the final
                    // range check so the fault arrives with full latency.
                    if (div_zero || (!sgn_reg && hi_ovf)) begin
                        err_pend_reg <= 1'b1;
                        state_reg    <= S_DONE;
                    end else begin
                        err_pend_reg <= 1'b0;
                        state_reg    <= S_DIVIDE;
                    end
                end

                S_DIVIDE: begin
                    pr_reg  <= pr_next;
                    q_reg   <= {q_reg[14:0], ge};
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd0) begin
                        state_reg <= S_FIXUP;
                    end
                end

                S_FIXUP: begin
                    q_reg        <= q_res;
                    pr_reg       <= r_res;
                    err_pend_reg <= sgn_ovf;
                    state_reg    <= S_DONE;
                end

                S_DONE: begin
                    quotient  <= err_pend_reg ? 16'h0000 : q_reg;
                    remainder <= err_pend_reg ? 16'h0000 : pr_reg;
                    error     <= err_pend_reg;
                    complete  <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// ---------------------------------------------------------------------------
// tb_divider
//
// Scoreboard bench for the divider. The driver computes each expected result
// with plain integer arithmetic and queues it; an independent monitor pops and
// compares whenever complete is seen, including the observed latency.
// ---------------------------------------------------------------------------
module tb_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_8_bit;
    logic        is_signed;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        complete;
    logic        error;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        err;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   txn   = 0;

    divider dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_8_bit  (is_8_bit),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .complete  (complete),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact integer division with the instruction's rules.
    function automatic exp_t model(input bit is8, input bit sg,
                                   input logic [31:0] a, input logic [15:0] b);
        exp_t   e;
        longint av;
        longint bv;
        longint qt;
        longint rt;
        longint lim;
        int     n;
        logic [15:0] mask;
        n    = is8 ? 8 : 16;
        mask = is8 ? 16'h00FF : 16'hFFFF;
        if (sg) begin
            if (is8) begin
                av = longint'($signed(a[15:0]));
                bv = longint'($signed(b[7:0]));
            end else begin
                av = longint'($signed(a));
                bv = longint'($signed(b));
            end
        end else begin
            if (is8) begin
                av = longint'(a[15:0]);
                bv = longint'(b[7:0]);
            end else begin
                av = longint'(a);
                bv = longint'(b);
            end
        end
        e.q = 16'h0000;
        e.r = 16'h0000;
        e.err = 1'b0;
        e.lat = n + 3;
        e.start_cyc = 0;
        if (bv == 0) begin
            e.err = 1'b1;
            e.lat = 2;
        end else begin
            qt = av / bv;
            rt = av % bv;
            if (!sg) begin
                if (qt >= (longint'(1) << n)) begin
                    e.err = 1'b1;
                    e.lat = 2;
                end
            end else begin
                lim = (longint'(1) << (n - 1)) - 1;
                if (qt > lim || qt < -lim) e.err = 1'b1;
            end
            if (!e.err) begin
                e.q = 16'(qt) & mask;
                e.r = 16'(rt) & mask;
            end
        end
        return e;
    endfunction

    // Called at a negedge; leaves the driver at the negedge after acceptance.
    task automatic issue(input bit expect_it, input bit is8, input bit sg,
                         input logic [31:0] a, input logic [15:0] b);
        exp_t e;
        e = model(is8, sg, a, b);
        e.start_cyc = cyc + 1;
        if (expect_it) sb.push_back(e);
        is_8_bit  = is8;
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 48'(busy), 48'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (complete !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (complete !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL timeout: no complete within 40 cycles, got 0 expected 1");
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (complete === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_complete: got complete=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                txn++;
                $display("txn %0d: q=%h r=%h err=%b lat=%0d (exp q=%h r=%h err=%b lat=%0d)",
                         txn, quotient, remainder, error, cyc - e.start_cyc,
                         e.q, e.r, e.err, e.lat);
                chk("quotient", 48'(quotient), 48'(e.q));
                chk("remainder", 48'(remainder), 48'(e.r));
                chk("error", 48'(error), 48'(e.err));
                chk("latency", 48'(cyc - e.start_cyc), 48'(e.lat));
                chk("busy_at_complete", 48'(busy), 48'd0);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [15:0] b;
        bit          is8;
        bit          sg;

        reset = 1'b1;
        start = 1'b0;
        is_8_bit = 1'b0;
        is_signed = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {quotient, remainder, busy, complete, error}, 48'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases, chained back-to-back
        issue(1, 0, 0, 32'h0001_0000, 16'h0003); wait_done();
        issue(1, 1, 0, 32'hDEAD_0064, 16'hAB07); wait_done();
        issue(1, 0, 0, 32'h1234_5678, 16'h0000); wait_done();
        issue(1, 1, 0, 32'h0000_1234, 16'h0000); wait_done();
        issue(1, 0, 0, 32'h0003_0000, 16'h0003); wait_done();
        issue(1, 0, 1, 32'hFFFF_FFF9, 16'h0002); wait_done();
        issue(1, 0, 1, 32'h0000_0007, 16'hFFFE); wait_done();
        issue(1, 0, 1, 32'h0001_0000, 16'h0001); wait_done();
        issue(1, 1, 1, 32'h0000_FF80, 16'h0001); wait_done();
        issue(1, 1, 1, 32'h0000_FF81, 16'h0001); wait_done();
        issue(1, 1, 1, 32'h0000_1234, 16'h0000); wait_done();
        issue(1, 0, 1, 32'h8000_0000, 16'h8000); wait_done();

        // start pulsed mid-division must be ignored
        issue(1, 0, 0, 32'h0001_0000, 16'h0003);
        repeat (4) @(negedge clk);
        dividend = 32'h0000_0010;
        divisor  = 16'h0002;
        is_8_bit = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset in the middle of a division: nothing should complete
        @(negedge clk);
        issue(0, 0, 0, 32'h0000_FFFF, 16'h0007);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs", {quotient, remainder, busy, complete, error}, 48'd0);
        reset = 1'b0;
        repeat (25) @(negedge clk);

        issue(1, 1, 0, 32'h0000_00FF, 16'h0010); wait_done();

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            is8 = 1'($urandom);
            sg  = 1'($urandom);
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (sg) begin
                    if (is8) a[15:8] = {8{a[7]}};
                    else     a[31:16] = {16{a[15]}};
                end else begin
                    if (is8) begin
                        if (b[7:0] != 8'h00) a[15:8] = a[15:8] % b[7:0];
                    end else begin
                        if (b != 16'h0000) a[31:16] = a[31:16] % b;
                    end
                end
            end
            issue(1, is8, sg, a, b);
            wait_done();
        end

        repeat (30) @(negedge clk);
        chk("scoreboard_empty", 48'(sb.size()), 48'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
